mem_bus_responder: RTL and testbench

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

---
 rtl/mem_bus_responder.sv | 125 ++++++++++++
 tb/tb_mem_bus_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Main-memory bus responder: accepts a line read/write, waits LATENCY cycles, then moves
// four 32-bit beats through a word-addressed SRAM, critical word first.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for mem_en; captures direction, line base and starting beat
// WAIT  | access latency countdown before the first beat
// RBEAT | drives one SRAM word per cycle onto the bus, four beats
// WBEAT | writes one SRAM word per valid initiator beat, stalls without valid
// DONE  | one-cycle completion pulse, back to IDLE
module mem_bus_responder #(
    parameter int BUSDATAW = 32,
    parameter int BUSADDRW = 32,
    parameter int MEMADDRW = 15,
    parameter int LATENCY  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_en,
    input  logic                rd_wr,
    input  logic [BUSADDRW-1:0] bus_addr,
    input  logic [BUSDATAW-1:0] bus_data_in,
    input  logic                bus_data_valid_in,
    output logic [BUSDATAW-1:0] bus_data_out,
    output logic                bus_data_oe,
    output logic                bus_data_valid,
    output logic                bus_done,
    output logic                bus_busy,
    output logic [MEMADDRW-1:0] sram_addr,
    input  logic [BUSDATAW-1:0] sram_rd_data,
    output logic [BUSDATAW-1:0] sram_wr_data,
    output logic                sram_we
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        RBEAT = 3'd2,
        WBEAT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          lat_cnt;
    logic [1:0]          beat_idx;
    logic [1:0]          beat_cnt;
    logic [MEMADDRW-3:0] line_base;
    logic                rd_wr_q;
    logic                beat_adv;

    // Only bus_addr[MEMADDRW+1:2] selects SRAM words; the rest is deliberately dropped.
    logic [BUSADDRW-1:0] unused_bus_addr;
    assign unused_bus_addr = bus_addr;

    assign beat_adv = (state == RBEAT) || ((state == WBEAT) && bus_data_valid_in);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_en) state_nxt = WAIT;
            WAIT:    if (lat_cnt == 4'd0) state_nxt = rd_wr_q ? WBEAT : RBEAT;
            RBEAT,
            WBEAT:   if (beat_adv && (beat_cnt == 2'd3)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt   <= '0;
            beat_idx  <= '0;
            beat_cnt  <= '0;
            line_base <= '0;
            rd_wr_q   <= 1'b0;
        end else if ((state == IDLE) && mem_en) begin
            rd_wr_q   <= rd_wr;
            line_base <= bus_addr[MEMADDRW+1:4];
            beat_idx  <= bus_addr[3:2];
            beat_cnt  <= '0;
            lat_cnt   <= 4'(LATENCY - 1);
        end else if ((state == WAIT) && (lat_cnt != 4'd0)) begin
            lat_cnt <= lat_cnt - 4'd1;
        end else if (beat_adv) begin
            // 2-bit index wraps inside the 16-byte line
            beat_idx <= beat_idx + 2'd1;
            beat_cnt <= beat_cnt + 2'd1;
        end
    end

    assign sram_addr = {line_base, beat_idx};

    always_comb begin
        bus_busy       = (state != IDLE);
        bus_data_oe    = 1'b0;
        bus_data_valid = 1'b0;
        bus_data_out   = '0;
        bus_done       = 1'b0;
        sram_we        = 1'b0;
        sram_wr_data   = '0;
        case (state)
            RBEAT: begin
                bus_data_oe    = 1'b1;
                bus_data_valid = 1'b1;
                bus_data_out   = sram_rd_data;
            end
            WBEAT: begin
                sram_we      = bus_data_valid_in;
                sram_wr_data = bus_data_valid_in ? bus_data_in : '0;
            end
            DONE:    bus_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: table of line transactions plus reset-abort and
// LATENCY=1 sequences, checked against a shadow copy of the SRAM contents.
`timescale 1ns/1ps

module tb_mem_bus_responder;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int MW  = 15;
    localparam int LAT = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_en, mem_en1;
    logic          rd_wr;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_data_in;
    logic          bus_data_valid_in;

    logic [DW-1:0] bus_data_out, sram_rd_data, sram_wr_data;
    logic          bus_data_oe, bus_data_valid, bus_done, bus_busy, sram_we;
    logic [MW-1:0] sram_addr;

    logic [DW-1:0] bus_data_out1, sram_rd_data1, sram_wr_data1;
    logic          bus_data_oe1, bus_data_valid1, bus_done1, bus_busy1, sram_we1;
    logic [MW-1:0] sram_addr1;

    logic [DW-1:0] mem    [0:(1<<MW)-1];
    logic [DW-1:0] shadow [0:(1<<MW)-1];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_bus_responder #(.BUSDATAW(DW), .BUSADDRW(AW), .MEMADDRW(MW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .mem_en(mem_en), .rd_wr(rd_wr), .bus_addr(bus_addr),
        .bus_data_in(bus_data_in), .bus_data_valid_in(bus_data_valid_in),
        .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe), .bus_data_valid(bus_data_valid),
        .bus_done(bus_done), .bus_busy(bus_busy), .sram_addr(sram_addr),
        .sram_rd_data(sram_rd_data), .sram_wr_data(sram_wr_data), .sram_we(sram_we)
    );

    mem_bus_responder #(.BUSDATAW(DW), .BUSADDRW(AW), .MEMADDRW(MW), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .mem_en(mem_en1), .rd_wr(rd_wr), .bus_addr(bus_addr),
        .bus_data_in(bus_data_in), .bus_data_valid_in(1'b0),
        .bus_data_out(bus_data_out1), .bus_data_oe(bus_data_oe1), .bus_data_valid(bus_data_valid1),
        .bus_done(bus_done1), .bus_busy(bus_busy1), .sram_addr(sram_addr1),
        .sram_rd_data(sram_rd_data1), .sram_wr_data(sram_wr_data1), .sram_we(sram_we1)
    );

    assign sram_rd_data  = mem[sram_addr];
    assign sram_rd_data1 = {16'hB1B1, 1'b0, sram_addr1};

    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_wr_data;
    end

    typedef struct {
        logic        rd_wr;
        logic [31:0] addr;
        logic [3:0]  gap;      // bit b: one idle cycle after write beat b
        logic        collide;  // pulse mem_en with another request during WAIT
        logic [14:0] word0;    // expected first SRAM word
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int tag);
        logic [14:0] wa;
        logic [31:0] wd;
        mem_en   = 1'b1;
        rd_wr    = v.rd_wr;
        bus_addr = v.addr;
        tick();
        mem_en   = 1'b0;
        bus_addr = 32'hDEAD_BEEF;
        for (int c = 0; c < LAT; c++) begin
            if (v.collide && c == 1) begin
                mem_en   = 1'b1;
                rd_wr    = ~v.rd_wr;
                bus_addr = 32'h0000_0200;
            end else begin
                mem_en = 1'b0;
                rd_wr  = v.rd_wr;
            end
            bus_data_valid_in = v.rd_wr;
            bus_data_in       = 32'hBAD0_0000 | 32'(c);
            #1;
            chk($sformatf("v%0d wait%0d busy/valid/we", tag, c),
                {29'd0, bus_busy, bus_data_valid, sram_we}, 32'h4);
            tick();
        end
        mem_en = 1'b0;
        for (int b = 0; b < 4; b++) begin
            wa = {v.word0[14:2], v.word0[1:0] + 2'(b)};
            if (!v.rd_wr) begin
                chk($sformatf("v%0d rbeat%0d oe/valid/we", tag, b),
                    {29'd0, bus_data_oe, bus_data_valid, sram_we}, 32'h6);
                chk($sformatf("v%0d rbeat%0d addr", tag, b), 32'(sram_addr), 32'(wa));
                chk($sformatf("v%0d rbeat%0d data", tag, b), bus_data_out, shadow[wa]);
                tick();
            end else begin
                wd = 32'hC0DE_0000 | 32'(tag << 8) | 32'(b);
                bus_data_valid_in = 1'b1;
                bus_data_in       = wd;
                #1;
                chk($sformatf("v%0d wbeat%0d we/oe", tag, b),
                    {30'd0, sram_we, bus_data_oe}, 32'h2);
                chk($sformatf("v%0d wbeat%0d addr", tag, b), 32'(sram_addr), 32'(wa));
                chk($sformatf("v%0d wbeat%0d wdata", tag, b), sram_wr_data, wd);
                shadow[wa] = wd;
                tick();
                if (v.gap[b]) begin
                    bus_data_valid_in = 1'b0;
                    bus_data_in       = 32'h0BAD_0BAD;
                    #1;
                    chk($sformatf("v%0d gap%0d we/busy/done", tag, b),
                        {29'd0, sram_we, bus_busy, bus_done}, 32'h2);
                    tick();
                end
            end
        end
        bus_data_valid_in = 1'b0;
        #1;
        chk($sformatf("v%0d done done/busy/oe/we", tag),
            {28'd0, bus_done, bus_busy, bus_data_oe, sram_we}, 32'hC);
        tick();
        chk($sformatf("v%0d after done/busy", tag), {30'd0, bus_done, bus_busy}, 32'h0);
        if (v.rd_wr) begin
            for (int b = 0; b < 4; b++) begin
                wa = {v.word0[14:2], v.word0[1:0] + 2'(b)};
                chk($sformatf("v%0d sram word %h", tag, wa), mem[wa], shadow[wa]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d0, d1;
        logic [14:0] wa;
        for (int i = 0; i < (1 << MW); i++) begin
            mem[i]    = {16'hA5A5, 16'(i)};
            shadow[i] = {16'hA5A5, 16'(i)};
        end
        vecs[0] = '{1'b0, 32'h0000_0040, 4'b0000, 1'b0, 15'h0010};
        vecs[1] = '{1'b0, 32'h0000_0048, 4'b0000, 1'b0, 15'h0012};
        vecs[2] = '{1'b1, 32'h0000_0100, 4'b0010, 1'b0, 15'h0040};
        vecs[3] = '{1'b0, 32'h0000_0100, 4'b0000, 1'b0, 15'h0040};
        vecs[4] = '{1'b0, 32'hFFFF_FF4F, 4'b0000, 1'b1, 15'h7FD3};
        vecs[5] = '{1'b1, 32'h0000_000C, 4'b0101, 1'b1, 15'h0003};
        vecs[6] = '{1'b0, 32'h0000_0007, 4'b0000, 1'b0, 15'h0001};

        mem_en = 1'b0; mem_en1 = 1'b0; rd_wr = 1'b0; bus_addr = '0;
        bus_data_in = 32'h1234_5678; bus_data_valid_in = 1'b1;
        reset = 1'b1;
        #1;
        chk("reset ctl outs", {27'd0, bus_busy, bus_data_oe, bus_data_valid, bus_done, sram_we}, 32'h0);
        chk("reset sram_addr", 32'(sram_addr), 32'h0);
        chk("reset wr_data", sram_wr_data, 32'h0);
        chk("reset data_out", bus_data_out, 32'h0);
        tick(); tick();
        reset = 1'b0;
        bus_data_valid_in = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset asserted mid-way through the second beat of a write to words 0x80..0x83
        d0 = 32'hFACE_0000;
        d1 = 32'hFACE_0001;
        mem_en = 1'b1; rd_wr = 1'b1; bus_addr = 32'h0000_0200;
        tick();
        mem_en = 1'b0;
        for (int c = 0; c < LAT; c++) tick();
        bus_data_valid_in = 1'b1; bus_data_in = d0;
        #1;
        chk("rst beat1 we", 32'(sram_we), 32'h1);
        shadow[15'h080] = d0;
        tick();
        bus_data_in = d1;
        #1;
        chk("rst beat2 addr", 32'(sram_addr), 32'h81);
        #2;
        reset = 1'b1;
        #1;
        chk("rst async ctl outs", {27'd0, bus_busy, bus_data_oe, bus_data_valid, bus_done, sram_we}, 32'h0);
        chk("rst async sram_addr", 32'(sram_addr), 32'h0);
        chk("rst async wr_data", sram_wr_data, 32'h0);
        chk("rst async data_out", bus_data_out, 32'h0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("post-rst idle%0d done/busy/we", c),
                {29'd0, bus_done, bus_busy, sram_we}, 32'h0);
            tick();
        end
        bus_data_valid_in = 1'b0;
        for (int b = 0; b < 4; b++) begin
            wa = 15'h080 + 15'(b);
            chk($sformatf("rst sram word %h", wa), mem[wa], shadow[wa]);
        end
        run_vec('{1'b0, 32'h0000_0200, 4'b0000, 1'b0, 15'h0080}, 7);

        // LATENCY=1 instance: wrapped read from 0x48
        mem_en1 = 1'b1; rd_wr = 1'b0; bus_addr = 32'h0000_0048;
        tick();
        mem_en1 = 1'b0;
        chk("lat1 wait busy/valid", {30'd0, bus_busy1, bus_data_valid1}, 32'h2);
        tick();
        for (int b = 0; b < 4; b++) begin
            wa = {13'h0004, 2'(2 + b)};
            chk($sformatf("lat1 beat%0d valid/oe", b), {30'd0, bus_data_valid1, bus_data_oe1}, 32'h3);
            chk($sformatf("lat1 beat%0d data", b), bus_data_out1, {16'hB1B1, 1'b0, wa});
            tick();
        end
        chk("lat1 done/busy/valid", {29'd0, bus_done1, bus_busy1, bus_data_valid1}, 32'h6);
        tick();
        chk("lat1 idle done/busy", {30'd0, bus_done1, bus_busy1}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
